usb_endpoint_ctrl: RTL and testbench
====================================

Name: usb_endpoint_ctrl

Overview:
Protocol controller for the bulk-transfer endpoint; sequences usb_rx, usb_tx and the shared 64-byte data buffer.
- Decodes usb_rx packet status (token, data, handshake, EOP) and drives usb_tx packet requests (DATA0/1, ACK, NAK).
- Arbitrates buffer ownership between the USB side and the AHB-Lite slave side.
- Sits between usb_rx/usb_tx and the AHB-Lite slave inside the SoC endpoint.

Parameters:
BUF_DEPTH, 64, data buffer capacity in bytes; buffer_occupancy is $clog2(BUF_DEPTH)+1 bits.
ACK_TIMEOUT, 200, clk cycles to wait for a host ACK after DATA transmission before abandoning the transfer.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_packet  in  3  usb_rx packet status: NONE/IN/OUT/DATA/ACK/DONE/NAK/ERR (codes 0..7)
store_rx_packet_data  in  1  usb_rx byte strobe, one cycle per received byte
buffer_occupancy  in  7  bytes currently held in the data buffer
tx_data_size  in  7  bytes the AHB side has loaded for IN transfer; 0 = nothing loaded
tx_done  in  1  usb_tx single-cycle pulse: requested packet fully sent including EOP
tx_packet  out  3  usb_tx request: 0 NONE, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK; held until tx_done
buffer_store  out  1  gated store_rx_packet_data into the buffer
clear_buffer  out  1  single-cycle buffer flush
rx_data_ready  out  1  OUT payload complete and valid; cleared by buffer_occupancy==0
rx_transfer_active  out  1  OUT transfer in progress
tx_transfer_active  out  1  IN transfer in progress
d_mode  out  1  1 = USB lines driven by usb_tx
rx_error  out  1  sticky: last OUT transfer failed; cleared on next OUT token

Behaviour:
Reset values: all outputs 0; state IDLE; data toggle = DATA0; timeout counter 0. rst mid-transfer returns to IDLE next edge with no clear_buffer pulse.

FSM states: IDLE, OUT_TOKEN, OUT_DATA, OUT_CHECK, SEND_ACK, SEND_NAK, IN_TOKEN, SEND_DATA, WAIT_ACK.

Transitions:
- IDLE, rx_packet==DONE after OUT token -> OUT_TOKEN; sets rx_transfer_active, clears rx_error.
- IDLE, DONE after IN token -> IN_TOKEN.
- OUT_TOKEN:
  - rx_data_ready==1 (buffer not yet drained by AHB) -> SEND_NAK.
  - rx_packet==DATA -> OUT_DATA.
- OUT_DATA:
  - buffer_store = store_rx_packet_data (combinational gate).
  - rx_packet==DONE -> OUT_CHECK.
  - rx_packet==ERR -> pulse clear_buffer, set rx_error, back to IDLE.
- OUT_CHECK (1 cycle):
  - buffer_occupancy > BUF_DEPTH is impossible; assert-check it.
  - Otherwise set rx_data_ready, toggle data bit -> SEND_ACK.
- SEND_ACK / SEND_NAK:
  - tx_packet = ACK/NAK, d_mode=1.
  - On tx_done -> IDLE; tx_packet and d_mode low in the same edge.
- IN_TOKEN:
  - tx_data_size==0 or rx_data_ready==1 -> SEND_NAK.
  - Otherwise -> SEND_DATA with tx_transfer_active=1.
- SEND_DATA:
  - tx_packet = DATA0/DATA1 per toggle, d_mode=1.
  - tx_done -> WAIT_ACK; timeout counter loaded 0.
- WAIT_ACK:
  - d_mode=0; counter increments each cycle.
  - rx_packet==ACK then DONE -> pulse clear_buffer, flip toggle, tx_transfer_active=0 -> IDLE.
  - Counter == ACK_TIMEOUT-1 or rx_packet ERR/NAK -> IDLE, buffer retained, toggle unchanged (host retries).

Boundaries and timing:
- Only DONE transitions out of IDLE; ERR in IDLE is ignored.
- rx_data_ready falls the cycle after buffer_occupancy reads 0.
- Simultaneous tx_done and rx_packet change: tx_done wins in SEND_* states.
- Latency: token DONE to tx_packet valid is 2 cycles (IDLE->*_TOKEN->SEND_*).

Decomposition:
- usb_pkg: rx_packet_t enum (8 codes), tx_packet_t enum, state_t enum, BUF_DEPTH default.
- One sub-module, usb_timeout_cnt: ACK_TIMEOUT-parameterised up-counter with clear, enable and rollover_flag.
- FSM and data toggle stay in usb_endpoint_ctrl.

Test Plan:
- OUT token DONE, DATA with 4 store pulses (occupancy 0->4), DONE -> buffer_store pulses 4, rx_data_ready=1, tx_packet=ACK until tx_done, toggle=DATA1.
- Second OUT before AHB drains -> tx_packet=NAK, no buffer_store, rx_data_ready stays 1.
- IN token with tx_data_size=8 -> tx_packet=DATA0, d_mode=1; tx_done, then ACK+DONE -> clear_buffer pulse, next IN sends DATA1.
- IN token, tx_data_size=8, no host ACK -> IDLE exactly ACK_TIMEOUT(200) cycles after tx_done, no clear_buffer, retry sends DATA0.
- IN token with tx_data_size=0 -> NAK within 2 cycles.
- OUT DATA ending in ERR -> clear_buffer 1 pulse, rx_error=1, no ACK sent; rst asserted mid-SEND_DATA -> all outputs 0 next edge.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types for the bulk endpoint controller: packet codes, FSM states
// and default sizing.
package usb_pkg;

    localparam int BUF_DEPTH_DEFAULT   = 64;
    localparam int ACK_TIMEOUT_DEFAULT = 200;

    typedef enum logic [2:0] {
        RX_NONE = 3'd0,
        RX_IN   = 3'd1,
        RX_OUT  = 3'd2,
        RX_DATA = 3'd3,
        RX_ACK  = 3'd4,
        RX_DONE = 3'd5,
        RX_NAK  = 3'd6,
        RX_ERR  = 3'd7
    } rx_packet_t;

    typedef enum logic [2:0] {
        TX_NONE  = 3'd0,
        TX_DATA0 = 3'd1,
        TX_DATA1 = 3'd2,
        TX_ACK   = 3'd3,
        TX_NAK   = 3'd4
    } tx_packet_t;

    typedef enum logic [3:0] {
        IDLE,
        OUT_TOKEN,
        OUT_DATA,
        OUT_CHECK,
        SEND_ACK,
        SEND_NAK,
        IN_TOKEN,
        SEND_DATA,
        WAIT_ACK
    } state_t;

    function automatic tx_packet_t data_pid(input logic toggle);
        return toggle ? TX_DATA1 : TX_DATA0;
    endfunction

endpackage

// File: rtl/usb_timeout_cnt.sv
// Free-running up-counter that wraps at ACK_TIMEOUT; rollover_flag marks the
// last count while counting is enabled.
module usb_timeout_cnt #(
    parameter int ACK_TIMEOUT = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic rollover_flag
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
        end
    end

    assign rollover_flag = enable && (count_reg == LAST);

endmodule

// File: rtl/usb_endpoint_ctrl.sv
// Bulk endpoint protocol FSM: sequences OUT/IN transactions between usb_rx,
// usb_tx and the shared data buffer, and tracks the DATA0/DATA1 toggle.
module usb_endpoint_ctrl
    import usb_pkg::*;
#(
    parameter int BUF_DEPTH   = BUF_DEPTH_DEFAULT,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  rx_packet,
    input  logic                        store_rx_packet_data,
    input  logic [$clog2(BUF_DEPTH):0]  buffer_occupancy,
    input  logic [$clog2(BUF_DEPTH):0]  tx_data_size,
    input  logic                        tx_done,
    output logic [2:0]                  tx_packet,
    output logic                        buffer_store,
    output logic                        clear_buffer,
    output logic                        rx_data_ready,
    output logic                        rx_transfer_active,
    output logic                        tx_transfer_active,
    output logic                        d_mode,
    output logic                        rx_error
);

    state_t     state_reg, state_next;
    rx_packet_t rx_pkt;
    rx_packet_t last_token_reg;
    logic       toggle_reg;
    logic       rx_data_ready_reg;
    logic       rx_error_reg;
    logic       rx_active_reg;
    logic       tx_active_reg;
    logic       ack_seen_reg;
    logic       clear_req;
    logic       in_ack_done;
    logic       cnt_clear;
    logic       cnt_enable;
    logic       cnt_rollover;

    assign rx_pkt = rx_packet_t'(rx_packet);

    usb_timeout_cnt #(
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) u_timeout (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .enable       (cnt_enable),
        .rollover_flag(cnt_rollover)
    );

    always_comb begin
        state_next   = state_reg;
        tx_packet    = TX_NONE;
        d_mode       = 1'b0;
        buffer_store = 1'b0;
        clear_req    = 1'b0;
        in_ack_done  = 1'b0;
        cnt_clear    = 1'b0;
        cnt_enable   = 1'b0;
        case (state_reg)
            IDLE: begin
                // The token itself only arms the direction; its DONE commits.
                if (rx_pkt == RX_DONE) begin
                    if (last_token_reg == RX_OUT) state_next = OUT_TOKEN;
                    else if (last_token_reg == RX_IN) state_next = IN_TOKEN;
                end
            end
            OUT_TOKEN: begin
                if (rx_data_ready_reg) state_next = SEND_NAK;
                else if (rx_pkt == RX_DATA) state_next = OUT_DATA;
            end
            OUT_DATA: begin
                buffer_store = store_rx_packet_data;
                if (rx_pkt == RX_DONE) begin
                    state_next = OUT_CHECK;
                end else if (rx_pkt == RX_ERR) begin
                    clear_req  = 1'b1;
                    state_next = IDLE;
                end
            end
            OUT_CHECK: state_next = SEND_ACK;
            SEND_ACK: begin
                tx_packet = TX_ACK;
                d_mode    = 1'b1;
                if (tx_done) state_next = IDLE;
            end
            SEND_NAK: begin
                tx_packet = TX_NAK;
                d_mode    = 1'b1;
                if (tx_done) state_next = IDLE;
            end
            IN_TOKEN: begin
                if (tx_data_size == '0 || rx_data_ready_reg) state_next = SEND_NAK;
                else state_next = SEND_DATA;
            end
            SEND_DATA: begin
                tx_packet = data_pid(toggle_reg);
                d_mode    = 1'b1;
                cnt_clear = 1'b1;
                if (tx_done) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                cnt_enable = 1'b1;
                if (rx_pkt == RX_DONE && ack_seen_reg) begin
                    clear_req   = 1'b1;
                    in_ack_done = 1'b1;
                    state_next  = IDLE;
                end else if (rx_pkt == RX_ERR || rx_pkt == RX_NAK || cnt_rollover) begin
                    // Payload stays in the buffer so the host retry resends it.
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            last_token_reg    <= RX_NONE;
            toggle_reg        <= 1'b0;
            rx_data_ready_reg <= 1'b0;
            rx_error_reg      <= 1'b0;
            rx_active_reg     <= 1'b0;
            tx_active_reg     <= 1'b0;
            ack_seen_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;

            if (state_reg == IDLE) begin
                if (rx_pkt == RX_IN || rx_pkt == RX_OUT) last_token_reg <= rx_pkt;
                else if (rx_pkt == RX_DONE) last_token_reg <= RX_NONE;
            end

            if (state_reg == OUT_CHECK || in_ack_done) toggle_reg <= ~toggle_reg;

            if (state_reg == OUT_CHECK) rx_data_ready_reg <= 1'b1;
            else if (buffer_occupancy == '0) rx_data_ready_reg <= 1'b0;

            if (state_reg == IDLE && state_next == OUT_TOKEN) begin
                rx_active_reg <= 1'b1;
                rx_error_reg  <= 1'b0;
            end else begin
                if (state_next == IDLE) rx_active_reg <= 1'b0;
                if (state_reg == OUT_DATA && rx_pkt == RX_ERR) rx_error_reg <= 1'b1;
            end

            if (state_reg == IN_TOKEN && state_next == SEND_DATA) tx_active_reg <= 1'b1;
            else if (state_next == IDLE) tx_active_reg <= 1'b0;

            if (state_reg != WAIT_ACK) ack_seen_reg <= 1'b0;
            else if (rx_pkt == RX_ACK) ack_seen_reg <= 1'b1;
        end
    end

    assign clear_buffer       = clear_req & ~rst;
    assign rx_data_ready      = rx_data_ready_reg;
    assign rx_transfer_active = rx_active_reg;
    assign tx_transfer_active = tx_active_reg;
    assign rx_error           = rx_error_reg;

    assert property (@(posedge clk) disable iff (rst)
        (state_reg == OUT_CHECK) |-> (int'(buffer_occupancy) <= BUF_DEPTH));

endmodule

// File: tb/tb_usb_endpoint_ctrl.sv
// Randomized scoreboard bench for usb_endpoint_ctrl: transaction-level model
// predicts tx requests and buffer flushes; a negedge monitor checks them.
module tb_usb_endpoint_ctrl;

    localparam int ACK_TIMEOUT = 200;
    localparam int EV_CLEAR    = 8;
    localparam logic [2:0] P_IN = 3'd1, P_OUT = 3'd2, P_DATA = 3'd3, P_ACK = 3'd4,
                           P_DONE = 3'd5, P_NAK = 3'd6, P_ERR = 3'd7;

    logic       tb_clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rx_packet = 3'd0;
    logic       store_rx_packet_data = 1'b0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [6:0] tx_data_size = 7'd0;
    logic       tx_done = 1'b0;
    logic [2:0] tx_packet;
    logic       buffer_store, clear_buffer, rx_data_ready, rx_transfer_active;
    logic       tx_transfer_active, d_mode, rx_error;

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   store_cnt = 0;
    bit   drain_req = 1'b0;
    logic [2:0] prev_tx = 3'd0;
    bit   model_rdr = 1'b0, model_toggle = 1'b0, model_err = 1'b0;

    usb_endpoint_ctrl dut (
        .clk                 (tb_clk),
        .rst                 (rst),
        .rx_packet           (rx_packet),
        .store_rx_packet_data(store_rx_packet_data),
        .buffer_occupancy    (buffer_occupancy),
        .tx_data_size        (tx_data_size),
        .tx_done             (tx_done),
        .tx_packet           (tx_packet),
        .buffer_store        (buffer_store),
        .clear_buffer        (clear_buffer),
        .rx_data_ready       (rx_data_ready),
        .rx_transfer_active  (rx_transfer_active),
        .tx_transfer_active  (tx_transfer_active),
        .d_mode              (d_mode),
        .rx_error            (rx_error)
    );

    always #5 tb_clk = ~tb_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every new tx request or buffer flush,
    // and models the buffer fill level seen by the DUT.
    always @(negedge tb_clk) begin
        if (tx_packet != prev_tx && tx_packet != 3'd0) begin
            if (exp_q.size() == 0) check("unexpected_tx", int'(tx_packet), 0);
            else check("tx_event", int'(tx_packet), exp_q.pop_front());
            check("d_mode_with_tx", int'(d_mode), 1);
        end
        if (clear_buffer) begin
            if (exp_q.size() == 0) check("unexpected_clear", int'(clear_buffer), 0);
            else check("clear_event", int'(clear_buffer) * EV_CLEAR, exp_q.pop_front());
        end
        prev_tx = tx_packet;
        if (buffer_store) store_cnt++;
        if (drain_req) begin
            buffer_occupancy = 7'd0;
            drain_req = 1'b0;
        end else if (clear_buffer) begin
            buffer_occupancy = 7'd0;
        end else if (buffer_store) begin
            buffer_occupancy = buffer_occupancy + 7'd1;
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] code);
        rx_packet = code;
        tick();
        rx_packet = 3'd0;
    endtask

    function automatic int all_outputs();
        return int'({tx_packet, buffer_store, clear_buffer, rx_data_ready,
                     rx_transfer_active, tx_transfer_active, d_mode, rx_error});
    endfunction

    task automatic wait_tx(output int n);
        n = 0;
        while (tx_packet == 3'd0 && n < 50) begin
            tick();
            n++;
        end
        check("tx_request_seen", int'(tx_packet != 3'd0), 1);
    endtask

    task automatic finish_tx(input int code);
        repeat ($urandom_range(0, 3)) tick();
        check("tx_hold", int'(tx_packet), code);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        check("tx_released", int'({tx_packet, d_mode}), 0);
    endtask

    task automatic send_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            store_rx_packet_data = 1'b1;
            tick();
            store_rx_packet_data = 1'b0;
            repeat ($urandom_range(0, 1)) tick();
        end
    endtask

    task automatic drain();
        drain_req = 1'b1;
        tick();
        tick();
        model_rdr = 1'b0;
    endtask

    task automatic reset_dut();
        drain_req = 1'b1;
        rst = 1'b1;
        tick();
        check("reset_outputs", all_outputs(), 0);
        tick();
        rst = 1'b0;
        model_rdr = 1'b0;
        model_toggle = 1'b0;
        model_err = 1'b0;
        tick();
        check("pending_events_at_reset", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic do_out(input int n, input bit err);
        int lat;
        int exp_store;
        store_cnt = 0;
        pulse(P_OUT);
        if (model_rdr) exp_q.push_back(4);
        pulse(P_DONE);
        check("rx_active_set", int'(rx_transfer_active), 1);
        model_err = 1'b0;
        if (model_rdr) begin
            wait_tx(lat);
            check("out_nak_latency", lat, 1);
            check("rx_error_cleared_by_token", int'(rx_error), 0);
            pulse(P_DATA);
            send_bytes(n);
            pulse(P_DONE);
            finish_tx(4);
            exp_store = 0;
        end else begin
            pulse(P_DATA);
            send_bytes(n);
            exp_store = n;
            if (err) begin
                exp_q.push_back(EV_CLEAR);
                pulse(P_ERR);
                model_err = 1'b1;
            end else begin
                exp_q.push_back(3);
                pulse(P_DONE);
                model_rdr = 1'b1;
                model_toggle = ~model_toggle;
                wait_tx(lat);
                finish_tx(3);
            end
        end
        tick();
        check("out_bytes_stored", store_cnt, exp_store);
        check("rx_data_ready", int'(rx_data_ready), int'(model_rdr));
        check("rx_error", int'(rx_error), int'(model_err));
        check("rx_active_clr", int'(rx_transfer_active), 0);
        $display("OUT bytes=%0d err=%0d stored=%0d rdr=%0d rx_error=%0d", n, err, store_cnt,
                 rx_data_ready, rx_error);
    endtask

    // mode 0: host ACKs, 1: host silent until timeout, 2: host NAK/ERR
    task automatic do_in(input int size, input int mode);
        int lat;
        int code;
        int n;
        tx_data_size = 7'(size);
        pulse(P_IN);
        if (size == 0 || model_rdr) begin
            exp_q.push_back(4);
            pulse(P_DONE);
            wait_tx(lat);
            check("in_nak_latency", lat, 1);
            finish_tx(4);
        end else begin
            code = model_toggle ? 2 : 1;
            exp_q.push_back(code);
            pulse(P_DONE);
            wait_tx(lat);
            check("in_data_latency", lat, 1);
            check("tx_active_set", int'(tx_transfer_active), 1);
            finish_tx(code);
            if (mode == 0) begin
                repeat ($urandom_range(0, 10)) tick();
                pulse(P_ACK);
                exp_q.push_back(EV_CLEAR);
                pulse(P_DONE);
                model_toggle = ~model_toggle;
            end else if (mode == 1) begin
                n = 0;
                while (tx_transfer_active && n < ACK_TIMEOUT + 20) begin
                    tick();
                    n++;
                end
                check("ack_timeout_cycles", n, ACK_TIMEOUT);
            end else begin
                repeat ($urandom_range(0, 10)) tick();
                pulse($urandom_range(0, 1) ? P_NAK : P_ERR);
            end
        end
        tick();
        check("tx_active_clr", int'(tx_transfer_active), 0);
        $display("IN size=%0d mode=%0d toggle_now=%0d", size, mode, model_toggle);
    endtask

    initial begin
        int lat;
        int r;
        reset_dut();

        do_out(4, 1'b0);
        do_out(5, 1'b0);
        drain();
        do_in(8, 0);

        reset_dut();
        do_in(8, 0);
        do_in(8, 0);

        reset_dut();
        do_in(8, 1);
        do_in(8, 0);
        do_in(0, 0);

        pulse(P_ERR);
        tick();
        check("idle_err_ignored", all_outputs(), 0);
        do_out(3, 1'b1);
        do_out(2, 1'b0);
        drain();

        reset_dut();
        tx_data_size = 7'd8;
        pulse(P_IN);
        exp_q.push_back(1);
        pulse(P_DONE);
        wait_tx(lat);
        rst = 1'b1;
        tick();
        check("reset_mid_send_data", all_outputs(), 0);
        $display("RESET mid SEND_DATA outputs=%0h", all_outputs());
        rst = 1'b0;
        tick();

        reset_dut();
        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 1) begin
                pulse(P_ERR);
                tick();
            end else if (r < 4) begin
                do_out(int'($urandom_range(1, 16)), $urandom_range(0, 3) == 0);
            end else begin
                do_in(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 64)),
                      ($urandom_range(0, 5) == 0) ? 1 : (($urandom_range(0, 2) == 0) ? 2 : 0));
            end
            if ($urandom_range(0, 1) == 1) drain();
        end

        tick();
        check("pending_events_at_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
